// File: rtl/mem_access_sequencer_if.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer_if
//   Bundles the signals between the two host-side requesters, the access
//   sequencer and the 8-bit memory model's control/data pins.
//
//   Requester side : req, req_we, req_sel, req_addr, req_wdata  (to sequencer)
//                    gnt, done, rdata, busy                     (from sequencer)
//   Memory side    : mem_rd_en, mem_wr_en, mem_addrreg_en, mem_datareg_en,
//                    mem_addrbuff_en, mem_databuff_en, mem_addr, mem_wdata
//                    (from sequencer), mem_rdata (to sequencer)
//
//   Modports:
//     slave  - the sequencer itself
//     master - the surroundings of the sequencer (requesters + memory)
// ---------------------------------------------------------------------------
interface mem_access_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 8
) ();

  // requester side
  logic [1:0]      req;
  logic [1:0]      req_we;
  logic [1:0]      req_sel;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [DW-1:0]   rdata;
  logic            busy;

  // memory side
  logic            mem_rd_en;
  logic            mem_wr_en;
  logic            mem_addrreg_en;
  logic            mem_datareg_en;
  logic            mem_addrbuff_en;
  logic            mem_databuff_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  req, req_we, req_sel, req_addr, req_wdata, mem_rdata,
    output gnt, done, rdata, busy,
           mem_rd_en, mem_wr_en, mem_addrreg_en, mem_datareg_en,
           mem_addrbuff_en, mem_databuff_en, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_sel, req_addr, req_wdata, mem_rdata,
    input  gnt, done, rdata, busy,
           mem_rd_en, mem_wr_en, mem_addrreg_en, mem_datareg_en,
           mem_addrbuff_en, mem_databuff_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer
//   Two-requester controller for the memory model's register/buffer datapath.
//   Arbitrates round-robin in IDLE, then sequences each access as an address
//   phase (ADDR) followed by a data phase (DATA). Reads wait RD_LAT cycles
//   in RWAIT and capture mem_rdata; DONE pulses done[owner] for one cycle.
//   All outputs are decoded from registered state and latched fields only,
//   so nothing combinational runs from req to the mem_* pins.
//
//   Ports:
//     clk  - clock
//     rst  - asynchronous, active-high reset (aborts any access in flight)
//     bus  - mem_access_sequencer_if.slave (requester + memory signals)
//
//   Parameters:
//     DW     - data width
//     AW     - address width
//     RD_LAT - cycles from the data-phase read strobe to valid mem_rdata (1..7)
//
//   Build option:
//     MEM_SEQ_ADDR_SKIP_EN - when defined, the last address loaded into each
//     resource pair (register / buffer) is tracked; an access whose address
//     matches the tracked, valid address of its pair skips the ADDR phase.
// ---------------------------------------------------------------------------
module mem_access_sequencer #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_access_sequencer_if.slave  bus
);

  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_RWAIT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_last;     // last grantee; reset to 1 so requester 0 wins first
  logic            r_owner;
  logic            r_we;
  logic            r_sel;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [2:0]      r_cnt;
  logic [DW-1:0]   r_rdata;
  logic [1:0]      r_gnt;

  logic            w_any_req;
  logic            w_win;
  logic            w_win_we;
  logic            w_win_sel;
  logic [AW-1:0]   w_win_addr;
  logic [DW-1:0]   w_win_wdata;
  logic            w_skip;

  // ---- arbitration (only consulted in IDLE) ----
  assign w_any_req = |bus.req;

  always_comb begin
    // both requesting: alternate away from the last grantee
    if (bus.req == 2'b11) w_win = ~r_last;
    else                  w_win = bus.req[1];
  end

  assign w_win_we    = w_win ? bus.req_we[1]  : bus.req_we[0];
  assign w_win_sel   = w_win ? bus.req_sel[1] : bus.req_sel[0];
  assign w_win_addr  = w_win ? bus.req_addr[2*AW-1:AW]  : bus.req_addr[AW-1:0];
  assign w_win_wdata = w_win ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];

`ifdef MEM_SEQ_ADDR_SKIP_EN
  // Index 0 tracks the register pair, index 1 the buffer pair. A pair's
  // address is refreshed whenever its ADDR phase runs, for reads and writes
  // alike, since both load the address resource.
  logic [1:0][AW-1:0] r_trk_addr;
  logic [1:0]         r_trk_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trk_addr <= '0;
      r_trk_vld  <= '0;
    end else if (r_state == S_ADDR) begin
      r_trk_addr[r_sel] <= r_addr;
      r_trk_vld[r_sel]  <= 1'b1;
    end
  end

  assign w_skip = r_trk_vld[w_win_sel] && (r_trk_addr[w_win_sel] == w_win_addr);
`else
  assign w_skip = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---- next state and Moore outputs ----
  always_comb begin
    w_next              = r_state;
    bus.mem_rd_en       = 1'b0;
    bus.mem_wr_en       = 1'b0;
    bus.mem_addrreg_en  = 1'b0;
    bus.mem_datareg_en  = 1'b0;
    bus.mem_addrbuff_en = 1'b0;
    bus.mem_databuff_en = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_wdata       = '0;
    bus.done            = 2'b00;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = w_skip ? S_DATA : S_ADDR;
      end
      S_ADDR: begin
        // the address phase always writes the address resource
        bus.mem_wr_en       = 1'b1;
        bus.mem_addrreg_en  = ~r_sel;
        bus.mem_addrbuff_en = r_sel;
        bus.mem_addr        = r_addr;
        w_next              = S_DATA;
      end
      S_DATA: begin
        bus.mem_wr_en       = r_we;
        bus.mem_rd_en       = ~r_we;
        bus.mem_datareg_en  = ~r_sel;
        bus.mem_databuff_en = r_sel;
        bus.mem_wdata       = r_we ? r_wdata : '0;
        w_next              = r_we ? S_DONE : S_RWAIT;
      end
      S_RWAIT: begin
        if (r_cnt == 3'd0) w_next = S_DONE;
      end
      S_DONE: begin
        bus.done = r_owner ? 2'b10 : 2'b01;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---- grant latch, read-latency counter, read-data capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_gnt   <= 2'b00;
    end else begin
      r_gnt <= 2'b00;
      if (r_state == S_IDLE && w_any_req) begin
        r_owner <= w_win;
        r_last  <= w_win;
        r_we    <= w_win_we;
        r_sel   <= w_win_sel;
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
        r_gnt   <= w_win ? 2'b10 : 2'b01;
      end
      if (r_state == S_DATA && !r_we) r_cnt <= CNT_LOAD;
      if (r_state == S_RWAIT) begin
        if (r_cnt == 3'd0) r_rdata <= bus.mem_rdata;
        else               r_cnt   <= r_cnt - 3'd1;
      end
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.rdata = r_rdata;
  assign bus.busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_access_sequencer
//   Directed bench for mem_access_sequencer with RD_LAT = 2. A small memory
//   model returns 0x0F on mem_rdata exactly RD_LAT cycles after a read strobe
//   and 0xEE otherwise. Expectations for the optional address-skip feature
//   follow the MEM_SEQ_ADDR_SKIP_EN define.
// ---------------------------------------------------------------------------
module tb_mem_access_sequencer;

  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_access_sequencer_if #(.DW(DW), .AW(AW)) bus ();

  mem_access_sequencer #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // memory read-latency model
  logic [RD_LAT-1:0] rd_pipe = '0;
  always @(posedge clk) rd_pipe <= {rd_pipe[RD_LAT-2:0], bus.mem_rd_en};
  assign bus.mem_rdata = rd_pipe[RD_LAT-1] ? 8'h0F : 8'hEE;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // {rd, wr, addrreg, datareg, addrbuff, databuff}
  function automatic logic [5:0] strb();
    return {bus.mem_rd_en, bus.mem_wr_en, bus.mem_addrreg_en,
            bus.mem_datareg_en, bus.mem_addrbuff_en, bus.mem_databuff_en};
  endfunction

  task automatic set_fields(input int idx, input logic we, input logic sel,
                            input logic [7:0] addr, input logic [7:0] wdata);
    bus.req_we[idx]             = we;
    bus.req_sel[idx]            = sel;
    bus.req_addr[idx*AW +: AW]  = addr;
    bus.req_wdata[idx*DW +: DW] = wdata;
  endtask

  // Issue one access from an idle sequencer, check the first cycle after the
  // grant edge and the grant-to-done latency, and return to IDLE.
  task automatic access(input int idx, input logic we, input logic sel,
                        input logic [7:0] addr, input logic [7:0] wdata,
                        input int exp_lat, input logic [5:0] exp_first,
                        input logic [7:0] exp_wd, input string tag);
    int lat;
    logic [1:0] onehot;
    onehot = (idx == 1) ? 2'b10 : 2'b01;
    set_fields(idx, we, sel, addr, wdata);
    bus.req = onehot;
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(onehot));
    chk({tag, "_strb1"}, 32'(strb()), 32'(exp_first));
    chk({tag, "_wdata1"}, 32'(bus.mem_wdata), 32'(exp_wd));
    bus.req = 2'b00;
    lat = 1;
    while (bus.done == 2'b00 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_done"}, 32'(bus.done), 32'(onehot));
    @(negedge clk);
  endtask

  int n_gnt, n_done, n_idle, lat;
  logic exp_g, cur_owner;

  initial begin
    bus.req       = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_sel   = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_gnt",   32'(bus.gnt),      32'd0);
    chk("rst_done",  32'(bus.done),     32'd0);
    chk("rst_rdata", 32'(bus.rdata),    32'd0);
    chk("rst_strb",  32'(strb()),       32'd0);
    chk("rst_addr",  32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- write, requester 0, register pair ----
    set_fields(0, 1'b1, 1'b0, 8'h3C, 8'hA5);
    bus.req = 2'b01;
    @(negedge clk);
    chk("w0_gnt",   32'(bus.gnt),      32'h1);
    chk("w0_busy",  32'(bus.busy),     32'd1);
    chk("w0_astrb", 32'(strb()),       32'b011000);
    chk("w0_addr",  32'(bus.mem_addr), 32'h3C);
    bus.req = 2'b00;
    @(negedge clk);
    chk("w0_dstrb", 32'(strb()),        32'b010100);
    chk("w0_wdata", 32'(bus.mem_wdata), 32'hA5);
    chk("w0_gnt0",  32'(bus.gnt),       32'd0);
    @(negedge clk);
    chk("w0_done",  32'(bus.done),      32'h1);
    chk("w0_strb0", 32'(strb()),        32'd0);
    @(negedge clk);
    chk("w0_idle",  32'(bus.busy),      32'd0);
    chk("w0_done0", 32'(bus.done),      32'd0);

    // ---- read, requester 1, buffer pair ----
    set_fields(1, 1'b0, 1'b1, 8'h10, 8'h00);
    bus.req = 2'b10;
    @(negedge clk);
    chk("r1_gnt",   32'(bus.gnt),      32'h2);
    chk("r1_astrb", 32'(strb()),       32'b010010);
    chk("r1_addr",  32'(bus.mem_addr), 32'h10);
    bus.req = 2'b00;
    @(negedge clk);
    chk("r1_dstrb", 32'(strb()), 32'b100001);
    @(negedge clk);
    chk("r1_wait1", 32'(strb()), 32'd0);
    @(negedge clk);
    chk("r1_wait2", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("r1_done",  32'(bus.done),  32'h2);
    chk("r1_rdata", 32'(bus.rdata), 32'h0F);
    @(negedge clk);
    chk("r1_hold",  32'(bus.rdata), 32'h0F);
    chk("r1_idle",  32'(bus.busy),  32'd0);

    // ---- both requesters held high: round-robin over four accesses ----
    set_fields(0, 1'b1, 1'b0, 8'h40, 8'h01);
    set_fields(1, 1'b1, 1'b1, 8'h50, 8'h02);
    bus.req   = 2'b11;
    n_gnt     = 0;
    n_done    = 0;
    n_idle    = 0;
    exp_g     = 1'b0;
    cur_owner = 1'b0;
    for (int c = 0; c < 60 && n_done < 4; c++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        chk("rr_gnt", 32'(bus.gnt), exp_g ? 32'h2 : 32'h1);
        cur_owner = exp_g;
        exp_g     = ~exp_g;
        n_gnt++;
        if (n_gnt == 4) bus.req = 2'b00;
      end
      if (bus.done != 2'b00) begin
        chk("rr_done", 32'(bus.done), cur_owner ? 32'h2 : 32'h1);
        n_done++;
      end
      if (!bus.busy && n_gnt > 0) n_idle++;
    end
    chk("rr_ndone", 32'(n_done), 32'd4);
    chk("rr_nidle", 32'(n_idle), 32'd3);
    @(negedge clk);

    // ---- reset during the DATA cycle of a write ----
    set_fields(0, 1'b1, 1'b0, 8'h77, 8'h99);
    bus.req = 2'b01;
    @(negedge clk);
    chk("ab_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 2'b00;
    @(negedge clk);
    chk("ab_dstrb", 32'(strb()), 32'b010100);
    #2 rst = 1'b1;
    #1;
    chk("ab_strb0", 32'(strb()),   32'd0);
    chk("ab_busy0", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("ab_nodone1", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("ab_nodone2", 32'(bus.done), 32'd0);
    rst = 1'b0;
    set_fields(0, 1'b1, 1'b0, 8'h77, 8'h33);
    set_fields(1, 1'b1, 1'b1, 8'h20, 8'h44);
    bus.req = 2'b11;
    @(negedge clk);
    chk("ab_rgnt",  32'(bus.gnt),      32'h1);
    chk("ab_rstrb", 32'(strb()),       32'b011000);
    chk("ab_raddr", 32'(bus.mem_addr), 32'h77);
    bus.req = 2'b00;
    lat = 1;
    while (bus.done == 2'b00 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ab_rlat", 32'(lat), 32'd3);
    @(negedge clk);

    // ---- repeated address on the register pair ----
    access(0, 1'b1, 1'b0, 8'h3C, 8'h11, 3, 6'b011000, 8'h00, "sk_w1");
`ifdef MEM_SEQ_ADDR_SKIP_EN
    access(0, 1'b1, 1'b0, 8'h3C, 8'h22, 2, 6'b010100, 8'h22, "sk_w2");
`else
    access(0, 1'b1, 1'b0, 8'h3C, 8'h22, 3, 6'b011000, 8'h00, "sk_w2");
`endif
    access(1, 1'b0, 1'b1, 8'h3C, 8'h00, 5, 6'b010010, 8'h00, "sk_rd");
    chk("sk_rdata", 32'(bus.rdata), 32'h0F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Two-requester controller for the 8-bit memory model's register/buffer datapath (address register, data register, address buffer, data buffer).
- Arbitrates round-robin between requesters and sequences each access as an address phase followed by a data phase, driving the memory's rd_en/wr_en and the per-resource enables.
- Returns read data and a completion pulse to the owning requester.
- Sits between the host-side masters and the memory block; it is the only driver of the memory's control inputs.

Parameters:
- DW, 8, data width
- AW, 8, address width
- RD_LAT, 1, cycles from data-phase read strobe to valid mem_rdata; legal range 1..7

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req  input  2  per-requester access request; bit i belongs to requester i
- req_we  input  2  per-requester direction: 1 write, 0 read
- req_sel  input  2  per-requester target: 0 register pair, 1 buffer pair
- req_addr  input  2*AW  per-requester address; requester i uses [i*AW +: AW]
- req_wdata  input  2*DW  per-requester write data, packed the same way
- gnt  output  2  one-hot, one-cycle pulse: request accepted and fields latched
- done  output  2  one-hot, one-cycle pulse: access complete
- rdata  output  DW  read data; valid on the done pulse, held until the next read completes
- busy  output  1  high whenever the state is not IDLE
- mem_rd_en  output  1  memory read strobe
- mem_wr_en  output  1  memory write strobe
- mem_addrreg_en  output  1  address register select
- mem_datareg_en  output  1  data register select
- mem_addrbuff_en  output  1  address buffer select
- mem_databuff_en  output  1  data buffer select
- mem_addr  output  AW  address to memory
- mem_wdata  output  DW  write data to memory
- mem_rdata  input  DW  read data from memory

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = requester 0 has priority, rdata = 0, internal latches cleared.
- Reset mid-operation aborts the access immediately:
  - all strobes drop asynchronously;
  - no done pulse is issued;
  - requesters must re-request.
- All outputs are driven from registered state/latches (Moore), so there are no combinational paths from req to the mem_* outputs.
- Arbitration happens only in IDLE, among asserted req bits.
  - If both are requesting, grant goes to the requester opposite the last grantee; the pointer updates on each grant.
  - A single requester always wins.
- On the grant edge, latch we, sel, addr and wdata of the winner, pulse gnt[i] for one cycle and move to ADDR.
- Requester handshake:
  - hold req and fields stable until gnt;
  - may drop req after gnt, or keep it high to request again after done;
  - req held high through done re-arbitrates in the IDLE cycle that follows.
- State ADDR (1 cycle):
  - mem_wr_en = 1;
  - mem_addrreg_en = 1 if sel = 0, else mem_addrbuff_en = 1;
  - mem_addr = latched address;
  - next state DATA.
- State DATA (1 cycle):
  - Write: mem_wr_en = 1, mem_datareg_en or mem_databuff_en per sel, mem_wdata = latched data; next state DONE.
  - Read: mem_rd_en = 1, same enable selection; next state RWAIT with the counter loaded to RD_LAT-1.
- State RWAIT: the counter decrements each cycle; at 0, capture mem_rdata into rdata and go to DONE. With RD_LAT = 1, the capture happens in the first RWAIT cycle.
- State DONE (1 cycle): pulse done[owner]; next state IDLE.
- In every state, at most one of mem_rd_en/mem_wr_en and at most one resource enable is high; all strobes are 0 in IDLE, RWAIT and DONE.
- Latency from the req edge sampled in IDLE to done:
  - write = 3 cycles (ADDR, DATA, DONE);
  - read = 3 + RD_LAT cycles.
- New req pulses while busy are ignored until IDLE; requests are not queued beyond the level-held req.

Optional Feature:
- Macro MEM_SEQ_ADDR_SKIP_EN.
- Enabled:
  - the block tracks the last address written to each resource pair (register and buffer), each with its own valid bit; both valid bits are cleared on reset;
  - if the granted access targets a pair whose tracked address is valid and equal to the latched address, ADDR is skipped (IDLE -> DATA);
  - latency is then 2 cycles for a write and 2 + RD_LAT for a read.
- Disabled: ADDR is always executed, and no tracking logic is present.

Test Plan:
- Reset then req[0] write, sel = 0, addr 0x3C, wdata 0xA5: gnt[0] pulse; ADDR cycle with mem_wr_en = 1, mem_addrreg_en = 1, mem_addr = 0x3C; DATA cycle with mem_wr_en = 1, mem_datareg_en = 1, mem_wdata = 0xA5; done[0] 3 cycles after the grant edge.
- req[1] read, sel = 1, addr 0x10, RD_LAT = 2, mem_rdata = 0x0F: mem_addrbuff_en in ADDR, mem_rd_en and mem_databuff_en in DATA, rdata = 0x0F with done[1] 5 cycles after the grant edge.
- Both req held high for 4 accesses: grants alternate 0, 1, 0, 1; gnt and done are never both bits high; busy stays 0 only in the single IDLE cycle between accesses.
- Assert rst during the DATA cycle of a write: all mem_* strobes are 0 immediately, no done pulse, and the next request starts at ADDR with requester 0 given priority.
- With MEM_SEQ_ADDR_SKIP_EN: write 0x3C/0x11, then write 0x3C/0x22 on sel = 0: the second access has no ADDR cycle and done arrives 2 cycles after the grant. A read to 0x3C with sel = 1 still performs ADDR.
- Without MEM_SEQ_ADDR_SKIP_EN, the same sequence runs ADDR on both writes.
